// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo_if_source slice.
//   DEFAULT_DATA_WIDTH : default entry width in bits
//   DEFAULT_DEPTH      : default number of entries (power of two, >= 2)
//   ptr_width()        : width of a read/write pointer for a given depth
package fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 512;
    localparam int DEFAULT_DEPTH      = 16;

    // Pointer width; never below 1 so a degenerate depth still elaborates.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Consumer-side stream interface of the FIFO.
//   data_vld : head entry is valid (driven by master)
//   data     : head entry payload (driven by master)
//   read     : consumer pops the head (driven by slave)
//
// Handshake: a transfer happens on a rising clock edge where data_vld and
// read are both high. read while data_vld is low has no effect. data_vld
// never depends combinationally on read, and data is stable while data_vld
// is high and no transfer has occurred.
interface fifo_if_t import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
);
    logic                  data_vld;
    logic [DATA_WIDTH-1:0] data;
    logic                  read;

    modport master (output data_vld, output data, input read);
    modport slave  (input data_vld, input data, output read);
endinterface

// File: rtl/fifo_ram_2p.sv
// Simple dual-port register array used as FIFO storage.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data
// Contents are intentionally not reset.
module fifo_ram_2p import fifo_pkg::*; #(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    localparam int ADDR_W    = ptr_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_W-1:0]     raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_if_source.sv
// First-word-fall-through FIFO whose consumer side is a fifo_if_t master.
//   clk         : clock, rising edge
//   rst_n       : asynchronous active-low reset
//   wr_en       : producer write request
//   wr_data     : producer payload
//   full        : occupancy == DEPTH
//   almost_full : occupancy >= AFULL_LEVEL
//   count       : current occupancy
//   overflow    : sticky, set when a write is dropped while full
//   out         : consumer side (data_vld, data out; read in)
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
module fifo_if_source import fifo_pkg::*; #(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int AFULL_LEVEL = DEPTH - 2,
    localparam int PTR_W      = ptr_width(DEPTH),
    localparam int CNT_W      = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  full,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    fifo_if_t.master              out
);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic                  overflow_q;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head_data;

    // A write while full is dropped even if a pop happens on the same edge.
    assign push = wr_en && !full;
    assign pop  = out.read && out.data_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (wr_en && full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    fifo_ram_2p #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_data),
        .raddr (rd_ptr),
        .rdata (head_data)
    );

    // Flags decode from the count register, so reset clears them at once.
    assign count        = count_q;
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_full  = (count_q >= CNT_W'(AFULL_LEVEL));
    assign overflow     = overflow_q;
    assign out.data_vld = (count_q != '0);
    // Head is read straight from storage; when empty it is left as whatever
    // the array holds rather than forced to zero.
    assign out.data     = head_data;

endmodule

// File: tb/tb_fifo_if_source.sv
module tb_fifo_if_source;
    import fifo_pkg::*;

    localparam int W     = 512;
    localparam int D     = 16;
    localparam int AF    = D - 2;
    localparam int CNT_W = $clog2(D) + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             wr_en = 1'b0;
    logic [W-1:0]     wr_data = '0;
    logic             full;
    logic             almost_full;
    logic [CNT_W-1:0] count;
    logic             overflow;

    fifo_if_t #(.DATA_WIDTH(W)) out_if ();

    fifo_if_source #(.DATA_WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .out         (out_if)
    );

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_q[$];
    bit           exp_ovf = 1'b0;
    int           errors = 0;
    int           checks = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] r;
        for (int i = 0; i < W / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Compare every visible output against the queue model.
    task automatic check_all(input string tag);
        check({tag, ".count"}, W'(count), W'(exp_q.size()));
        check({tag, ".vld"}, W'(out_if.data_vld), W'(exp_q.size() != 0));
        check({tag, ".full"}, W'(full), W'(exp_q.size() == D));
        check({tag, ".afull"}, W'(almost_full), W'(exp_q.size() >= AF));
        check({tag, ".ovf"}, W'(overflow), W'(exp_ovf));
        if (exp_q.size() != 0) check({tag, ".data"}, out_if.data, exp_q[0]);
    endtask

    // ---------------- driver ----------------
    // Called just after a rising edge; applies inputs for one clock cycle.
    task automatic cycle(input string tag, input bit we, input logic [W-1:0] d, input bit rd);
        bit do_pop, do_push;
        wr_en       = we;
        wr_data     = d;
        out_if.read = rd;
        do_pop  = rd && (exp_q.size() != 0);
        do_push = we && (exp_q.size() < D);
        if (we && exp_q.size() == D) exp_ovf = 1'b1;
        @(posedge clk);
        #1;
        if (do_pop) void'(exp_q.pop_front());
        if (do_push) exp_q.push_back(d);
        check_all(tag);
    endtask

    task automatic apply_reset(input string tag);
        wr_en       = 1'b0;
        out_if.read = 1'b0;
        rst_n       = 1'b0;
        exp_q.delete();
        exp_ovf     = 1'b0;
        #1;
        check_all(tag);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [W-1:0] w;
        int wb, rb;
        out_if.read = 1'b0;

        // Reset values
        #2;
        check_all("reset");
        #10;
        rst_n = 1'b1;

        // Three writes, no reads
        for (int i = 1; i <= 3; i++) cycle("wr3", 1'b1, W'(i), 1'b0);

        // Drain with read held, then an ignored read on empty
        for (int i = 0; i < 4; i++) cycle("rd4", 1'b0, '0, 1'b1);

        // Fill to full, drop one write, then drain
        for (int i = 0; i < D; i++) cycle("fill", 1'b1, W'(32'h100 + i), 1'b0);
        cycle("drop", 1'b1, W'(32'hDEAD), 1'b0);
        cycle("drop_rd", 1'b1, W'(32'hBEEF), 1'b1);
        for (int i = 0; i < D + 1; i++) cycle("drain", 1'b0, '0, 1'b1);

        // Overflow is sticky until reset
        apply_reset("rst_ovf");

        // Steady-state push+pop across pointer wrap from count 5
        for (int i = 0; i < 5; i++) cycle("pre5", 1'b1, rand_word(), 1'b0);
        for (int i = 0; i < 40; i++) cycle("stream", 1'b1, rand_word(), 1'b1);

        // Mid-stream reset at count 7, with overflow pending
        for (int i = 0; i < 11; i++) cycle("to_full", 1'b1, rand_word(), 1'b0);
        cycle("ovf2", 1'b1, rand_word(), 1'b0);
        for (int i = 0; i < 9; i++) cycle("to7", 1'b0, '0, 1'b1);
        check("cnt7", W'(count), W'(7));
        apply_reset("rst_mid");
        w = rand_word();
        cycle("post_rst", 1'b1, w, 1'b0);
        check("post_rst.lat", out_if.data, w);

        // Random traffic, bias changed in phases to reach both full and empty
        for (int i = 0; i < 10000; i++) begin
            case ((i / 500) % 3)
                0:       begin wb = 75; rb = 35; end
                1:       begin wb = 30; rb = 75; end
                default: begin wb = 50; rb = 50; end
            endcase
            cycle("rand", $urandom_range(0, 99) < wb, rand_word(), $urandom_range(0, 99) < rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
